// File: rtl/bist_pkg.sv
// ----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST controller and the signature checker.
//   - State encodings for the checker FSM (plain constants plus an enum
//     typedef built on them, so older code using the constants still links).
//   - Default MISR polynomial and seed values.
// Optional feature macro used by the checker: BIST_CHK_COUNT_EN.
// ----------------------------------------------------------------------------
package bist_pkg;

   localparam logic [1:0] BIST_ST_IDLE    = 2'd0;
   localparam logic [1:0] BIST_ST_COLLECT = 2'd1;
   localparam logic [1:0] BIST_ST_EVAL    = 2'd2;
   localparam logic [1:0] BIST_ST_REPORT  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = BIST_ST_IDLE,
      ST_COLLECT = BIST_ST_COLLECT,
      ST_EVAL    = BIST_ST_EVAL,
      ST_REPORT  = BIST_ST_REPORT
   } bist_state_t;

   // CRC-16/CCITT style polynomial is the default MISR feedback.
   localparam logic [15:0] BIST_DEFAULT_POLY = 16'h1021;
   localparam logic [15:0] BIST_DEFAULT_SEED = 16'h0000;

   // Saturating 8-bit increment used by the capture counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/bist_misr.sv
// ----------------------------------------------------------------------------
// bist_misr
// Multiple-input signature register compacting circuit-under-test responses.
// Ports:
//   CLK    in            rising-edge clock
//   RESET  in            asynchronous active-high reset, forces sig = SEED
//   load   in            reload sig with SEED (start of a run)
//   shift  in            compact 'data' into sig this cycle
//   data   in  RESP_W    response word, zero-extended to SIG_W
//   sig    out SIG_W     current signature
// load has priority over shift; with neither asserted sig holds.
// ----------------------------------------------------------------------------
module bist_misr
   import bist_pkg::*;
#(
   parameter int unsigned       RESP_W = 8,
   parameter int unsigned       SIG_W  = 16,
   parameter logic [SIG_W-1:0]  POLY   = BIST_DEFAULT_POLY,
   parameter logic [SIG_W-1:0]  SEED   = BIST_DEFAULT_SEED
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              load,
   input  logic              shift,
   input  logic [RESP_W-1:0] data,
   output logic [SIG_W-1:0]  sig
);

   logic [SIG_W-1:0] data_ext;
   logic [SIG_W-1:0] feedback;
   logic [SIG_W-1:0] next_sig;

   // Zero-extend the response this way so SIG_W == RESP_W needs no
   // zero-width replication.
   always_comb begin
      data_ext              = '0;
      data_ext[RESP_W-1:0]  = data;
   end

   // Galois-style step: shift left, fold in the polynomial when the bit
   // falling off the top was set, then mix in the new response.
   always_comb begin
      feedback = sig[SIG_W-1] ? POLY : '0;
      next_sig = {sig[SIG_W-2:0], 1'b0} ^ feedback ^ data_ext;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sig <= SEED;
      end else if (load) begin
         sig <= SEED;
      end else if (shift) begin
         sig <= next_sig;
      end
   end

endmodule

// File: rtl/bist_signature_checker.sv
// ----------------------------------------------------------------------------
// bist_signature_checker
// Collects circuit-under-test responses into a MISR during a BIST run and
// compares the final signature against GOLDEN_SIG, reporting PASS/FAIL until
// the consumer acknowledges.
// Ports:
//   CLK           in            rising-edge clock
//   RESET         in            asynchronous active-high reset
//   RUNNING       in            controller run indication
//   CAP_EN        in            response strobe, RESP valid this cycle
//   BIST_END      in            end-of-test pulse
//   RESP          in  RESP_W    circuit-under-test response
//   ACK           in            consumer acknowledge of the result
//   SIGNATURE     out SIG_W     current MISR contents
//   RESULT_VALID  out           PASS/FAIL are valid
//   PASS          out           signature matched
//   FAIL          out           signature mismatched
// Optional macro BIST_CHK_COUNT_EN: adds an 8-bit saturating capture counter
// and requires it to equal EXP_CAPTURES for a pass. Ports are identical in
// both builds.
// ----------------------------------------------------------------------------
module bist_signature_checker
   import bist_pkg::*;
#(
   parameter int unsigned       RESP_W       = 8,
   parameter int unsigned       SIG_W        = 16,
   parameter logic [SIG_W-1:0]  POLY         = BIST_DEFAULT_POLY,
   parameter logic [SIG_W-1:0]  SEED         = BIST_DEFAULT_SEED,
   parameter logic [SIG_W-1:0]  GOLDEN_SIG   = 16'h0000,
   parameter int unsigned       EXP_CAPTURES = 81
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              RUNNING,
   input  logic              CAP_EN,
   input  logic              BIST_END,
   input  logic [RESP_W-1:0] RESP,
   input  logic              ACK,
   output logic [SIG_W-1:0]  SIGNATURE,
   output logic              RESULT_VALID,
   output logic              PASS,
   output logic              FAIL
);

   bist_state_t state;
   logic        load;
   logic        shift;
   logic        match;
   logic        sig_match;

   // A run starts the cycle RUNNING is seen in IDLE. Captures are taken in
   // COLLECT while the controller is running; a strobe coincident with
   // BIST_END is still taken even if RUNNING has already dropped, so the
   // final response is never lost.
   always_comb begin
      load  = (state == ST_IDLE) && RUNNING;
      shift = (state == ST_COLLECT) && CAP_EN && (RUNNING || BIST_END);
   end

   bist_misr #(
      .RESP_W (RESP_W),
      .SIG_W  (SIG_W),
      .POLY   (POLY),
      .SEED   (SEED)
   ) u_misr (
      .CLK    (CLK),
      .RESET  (RESET),
      .load   (load),
      .shift  (shift),
      .data   (RESP),
      .sig    (SIGNATURE)
   );

   assign sig_match = (SIGNATURE == GOLDEN_SIG);

`ifdef BIST_CHK_COUNT_EN
   logic [7:0] count;

   // Counts accepted captures for the run; cleared together with the MISR
   // load so it always describes the current run only.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count <= 8'd0;
      end else if (load) begin
         count <= 8'd0;
      end else if (shift) begin
         count <= sat_inc8(count);
      end
   end

   assign match = sig_match && (32'(count) == EXP_CAPTURES);
`else
   logic unused_cfg;

   // EXP_CAPTURES only matters when the counter is built.
   assign unused_cfg = ^EXP_CAPTURES;
   assign match      = sig_match;
`endif

   // Main control FSM. EVAL lasts exactly one cycle and registers the
   // verdict, so RESULT_VALID rises on the second edge counting the one that
   // samples BIST_END. REPORT freezes everything (the MISR only shifts in
   // COLLECT) until ACK returns to IDLE. PASS and FAIL are only ever set as a
   // complementary pair alongside RESULT_VALID and cleared together with it.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= ST_IDLE;
         RESULT_VALID <= 1'b0;
         PASS         <= 1'b0;
         FAIL         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (RUNNING) begin
                  state <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (BIST_END) begin
                  state <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               state        <= ST_REPORT;
               RESULT_VALID <= 1'b1;
               PASS         <= match;
               FAIL         <= !match;
            end
            ST_REPORT: begin
               if (ACK) begin
                  state        <= ST_IDLE;
                  RESULT_VALID <= 1'b0;
                  PASS         <= 1'b0;
                  FAIL         <= 1'b0;
               end
            end
            default: begin
               state        <= ST_IDLE;
               RESULT_VALID <= 1'b0;
               PASS         <= 1'b0;
               FAIL         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bist_signature_checker.sv
// ----------------------------------------------------------------------------
// tb_bist_signature_checker
// Directed and randomized runs of bist_signature_checker against a reference
// model that keeps the list of captured responses and computes the expected
// signature arithmetically at the end of each run.
// Honours BIST_CHK_COUNT_EN when the design is built with it.
// ----------------------------------------------------------------------------
module tb_bist_signature_checker;

   localparam int unsigned RESP_W       = 8;
   localparam int unsigned SIG_W        = 16;
   localparam logic [15:0] POLY         = 16'h1021;
   localparam logic [15:0] SEED         = 16'h0000;
   localparam logic [15:0] GOLDEN_SIG   = 16'h0003;
   localparam int unsigned EXP_CAPTURES = 81;

   logic              CLK = 1'b0;
   logic              RESET;
   logic              RUNNING;
   logic              CAP_EN;
   logic              BIST_END;
   logic [RESP_W-1:0] RESP;
   logic              ACK;
   logic [SIG_W-1:0]  SIGNATURE;
   logic              RESULT_VALID;
   logic              PASS;
   logic              FAIL;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0]  plan[$];
   logic [7:0]  captured[$];
   logic [15:0] exp_sig;
   logic        exp_pass;

   bist_signature_checker #(
      .RESP_W       (RESP_W),
      .SIG_W        (SIG_W),
      .POLY         (POLY),
      .SEED         (SEED),
      .GOLDEN_SIG   (GOLDEN_SIG),
      .EXP_CAPTURES (EXP_CAPTURES)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .RUNNING      (RUNNING),
      .CAP_EN       (CAP_EN),
      .BIST_END     (BIST_END),
      .RESP         (RESP),
      .ACK          (ACK),
      .SIGNATURE    (SIGNATURE),
      .RESULT_VALID (RESULT_VALID),
      .PASS         (PASS),
      .FAIL         (FAIL)
   );

   always #5 CLK = ~CLK;

   // Expected signature: treat the register as an integer, double it, and
   // when it overflows 16 bits drop the carry and fold in the polynomial.
   function automatic logic [15:0] model_signature();
      int s;
      s = int'(SEED);
      foreach (captured[i]) begin
         s = s * 2;
         if (s >= 65536) s = (s - 65536) ^ int'(POLY);
         s = s ^ int'(captured[i]);
      end
      return s[15:0];
   endfunction

   function automatic logic model_pass(input logic [15:0] sig);
      logic ok;
      ok = (sig == GOLDEN_SIG);
`ifdef BIST_CHK_COUNT_EN
      ok = ok && (captured.size() == EXP_CAPTURES);
`endif
      return ok;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkIdleOutputs(input string tag, input logic [15:0] sig);
      checkOutput(tag, {SIGNATURE, RESULT_VALID, PASS, FAIL}, {sig, 3'b000});
   endtask

   // Drives one complete run using the responses in 'plan'. The final
   // response can coincide with BIST_END; random idle cycles are inserted
   // between captures. Checks the EVAL and REPORT phases, holds ACK low for
   // ack_wait cycles, then acknowledges.
   task automatic applyStimulus(input bit coincident, input bit gaps,
                                input int ack_wait);
      captured.delete();
      RUNNING = 1'b1;
      tick();
      foreach (plan[i]) begin
         CAP_EN   = 1'b1;
         RESP     = plan[i];
         BIST_END = (coincident && i == plan.size() - 1);
         captured.push_back(plan[i]);
         tick();
         CAP_EN   = 1'b0;
         BIST_END = 1'b0;
         RESP     = 8'($urandom);
         if (gaps && !(coincident && i == plan.size() - 1) &&
             $urandom_range(0, 2) == 0)
            tick();
      end
      if (!coincident) begin
         BIST_END = 1'b1;
         tick();
         BIST_END = 1'b0;
      end
      RUNNING  = 1'b0;
      exp_sig  = model_signature();
      exp_pass = model_pass(exp_sig);
      checkOutput("eval_sig", {16'd0, SIGNATURE}, {16'd0, exp_sig});
      checkOutput("eval_not_valid", {31'd0, RESULT_VALID}, 32'd0);
      tick();
      checkOutput("report", {SIGNATURE, RESULT_VALID, PASS, FAIL},
                  {exp_sig, 1'b1, exp_pass, !exp_pass});
      for (int k = 0; k < ack_wait; k++) begin
         tick();
         checkOutput("report_hold", {SIGNATURE, RESULT_VALID, PASS, FAIL},
                     {exp_sig, 1'b1, exp_pass, !exp_pass});
      end
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
      checkIdleOutputs("after_ack", exp_sig);
   endtask

   initial begin
      RESET    = 1'b1;
      RUNNING  = 1'b0;
      CAP_EN   = 1'b0;
      BIST_END = 1'b0;
      RESP     = 8'h00;
      ACK      = 1'b0;
      #1;
      checkIdleOutputs("reset_state", SEED);
      #2;
      RESET = 1'b0;
      tick();

      // IDLE ignores BIST_END, CAP_EN and ACK.
      BIST_END = 1'b1;
      CAP_EN   = 1'b1;
      RESP     = 8'h55;
      ACK      = 1'b1;
      tick();
      tick();
      BIST_END = 1'b0;
      CAP_EN   = 1'b0;
      ACK      = 1'b0;
      checkIdleOutputs("idle_ignores", SEED);

      // Two captures of 01 then BIST_END: signature 0003.
      plan = '{8'h01, 8'h01};
      applyStimulus(1'b0, 1'b0, 20);
      checkOutput("golden_run_sig", {16'd0, exp_sig}, 32'h0000_0003);

      // Second response 00: signature 0002, mismatch.
      plan = '{8'h01, 8'h00};
      applyStimulus(1'b0, 1'b0, 2);

      // Final response coincident with BIST_END is included.
      plan = '{8'h01, 8'h01};
      applyStimulus(1'b1, 1'b0, 1);

      // Asynchronous reset mid-COLLECT: outputs drop without a clock edge and
      // nothing is reported afterwards.
      RUNNING = 1'b1;
      tick();
      CAP_EN = 1'b1;
      RESP   = 8'hA5;
      tick();
      tick();
      CAP_EN = 1'b0;
      #2;
      RESET = 1'b1;
      #1;
      checkIdleOutputs("async_reset_collect", SEED);
      RUNNING = 1'b0;
      #1;
      RESET = 1'b0;
      BIST_END = 1'b1;
      tick();
      BIST_END = 1'b0;
      tick();
      tick();
      checkIdleOutputs("no_report_after_reset", SEED);

      // RUNNING low in COLLECT holds the signature without aborting.
      RUNNING = 1'b1;
      tick();
      CAP_EN = 1'b1;
      RESP   = 8'h01;
      tick();
      CAP_EN  = 1'b0;
      RUNNING = 1'b0;
      tick();
      tick();
      tick();
      checkOutput("hold_running_low", {SIGNATURE, RESULT_VALID}, {16'h0001, 1'b0});
      BIST_END = 1'b1;
      tick();
      BIST_END = 1'b0;
      tick();
      captured.delete();
      captured.push_back(8'h01);
      exp_pass = model_pass(model_signature());
      checkOutput("hold_then_report", {SIGNATURE, RESULT_VALID, PASS, FAIL},
                  {16'h0001, 1'b1, exp_pass, !exp_pass});

      // Asynchronous reset mid-REPORT discards the verdict.
      #2;
      RESET = 1'b1;
      #1;
      checkIdleOutputs("async_reset_report", SEED);
      #1;
      RESET = 1'b0;
      tick();

      // Randomized runs.
      for (int r = 0; r < 8; r++) begin
         plan.delete();
         for (int j = 0; j < int'($urandom_range(1, 12)); j++)
            plan.push_back(8'($urandom));
         applyStimulus(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 3)));
      end

`ifdef BIST_CHK_COUNT_EN
      // Correct signature with 80 captures fails, with 81 passes.
      plan.delete();
      for (int j = 0; j < 78; j++) plan.push_back(8'h00);
      plan.push_back(8'h01);
      plan.push_back(8'h01);
      applyStimulus(1'b0, 1'b0, 0);
      checkOutput("count80_fail", {30'd0, PASS, FAIL}, 32'd1);
      plan.push_front(8'h00);
      applyStimulus(1'b0, 1'b0, 0);
      checkOutput("count81_pass", {30'd0, PASS, FAIL}, 32'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
